// File: rtl/keccak_squeeze.sv
// keccak_squeeze: squeeze-phase reader for Keccak-f[1600].
// Latches a permuted state, streams the rate lanes out as 64-bit words over
// valid/ready, and hands the state back to the permutation core whenever
// more words are requested than one rate block holds.
module keccak_squeeze #(
    parameter int RATE_LANES = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1599:0] state_in,
    input  logic [7:0]    out_lanes,
    output logic          busy,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          perm_req,
    output logic [1599:0] perm_state,
    input  logic          perm_done,
    input  logic [1599:0] perm_result,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_PERM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index of the final rate lane in a block; crossing it means re-permuting.
    localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

    state_t          state, state_nxt;
    logic [1599:0]   state_reg, state_reg_nxt;
    logic [7:0]      remaining, remaining_nxt;
    logic [4:0]      lane_idx, lane_idx_nxt;

    // Lane view of the latched state: lane i is bits [64*i +: 64].
    logic [24:0][63:0] lanes;
    assign lanes = state_reg;

    // Register all state; async reset aborts any squeeze in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            state_reg <= '0;
            remaining <= '0;
            lane_idx  <= '0;
        end else begin
            state     <= state_nxt;
            state_reg <= state_reg_nxt;
            remaining <= remaining_nxt;
            lane_idx  <= lane_idx_nxt;
        end
    end

    // Next-state and datapath update; registers hold unless a rule fires.
    always_comb begin
        state_nxt     = state;
        state_reg_nxt = state_reg;
        remaining_nxt = remaining;
        lane_idx_nxt  = lane_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_reg_nxt = state_in;
                    remaining_nxt = out_lanes;
                    lane_idx_nxt  = '0;
                    state_nxt     = (out_lanes == 8'd0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (dout_ready) begin
                    remaining_nxt = remaining - 8'd1;
                    lane_idx_nxt  = lane_idx + 5'd1;
                    // Last word wins over the block boundary: a request that
                    // ends exactly on a block never triggers a permutation.
                    if (remaining == 8'd1) begin
                        state_nxt = S_DONE;
                    end else if (lane_idx == LAST_LANE) begin
                        lane_idx_nxt = '0;
                        state_nxt    = S_PERM;
                    end
                end
            end
            S_PERM: begin
                if (perm_done) begin
                    state_reg_nxt = perm_result;
                    state_nxt     = S_EMIT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode registers only, so no input reaches an output in the same cycle.
    always_comb begin
        busy       = (state != S_IDLE);
        dout_valid = (state == S_EMIT);
        dout_last  = (state == S_EMIT) && (remaining == 8'd1);
        perm_req   = (state == S_PERM);
        done       = (state == S_DONE);
        dout       = (state == S_EMIT) ? lanes[lane_idx] : 64'd0;
    end

    assign perm_state = state_reg;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: table of directed squeezes, hand-written reset
// and ignored-start sequences, and randomized squeezes against a block model.
module tb_keccak_squeeze;

    localparam int RL = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1599:0] state_in;
    logic [7:0]    out_lanes;
    logic          busy;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          perm_req;
    logic [1599:0] perm_state;
    logic          perm_done;
    logic [1599:0] perm_result;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Model: blk[b] is the state from which block b's words are read.
    // Word k of the stream is lane (k % RL) of blk[k / RL].
    logic [1599:0] blk [0:7];

    keccak_squeeze #(.RATE_LANES(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .out_lanes(out_lanes), .busy(busy), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .perm_req(perm_req), .perm_state(perm_state), .perm_done(perm_done),
        .perm_result(perm_result), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"},  64'(busy), 64'd0);
        chk({nm, "_valid"}, 64'(dout_valid), 64'd0);
        chk({nm, "_last"},  64'(dout_last), 64'd0);
        chk({nm, "_preq"},  64'(perm_req), 64'd0);
        chk({nm, "_done"},  64'(done), 64'd0);
        chk({nm, "_dout"},  dout, 64'd0);
    endtask

    function automatic logic [1599:0] fill_lanes(input int base);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) s[64*i +: 64] = 64'(base + i);
        return s;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // One complete squeeze of n words from blk[]; plays consumer and perm core.
    task automatic run(input int n, input logic [15:0] rpat, input int rlen,
                       input bit rrand, input int pdly,
                       output int xfers, output int perms);
        int k, p, w, cyc;
        bit fin, rdy, stalled;
        logic [63:0] prev, exp;
        k = 0; p = 0; w = 0; cyc = 0; fin = 0; stalled = 0; prev = '0;
        @(negedge clk);
        start = 1'b1; state_in = blk[0]; out_lanes = 8'(n); dout_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            rdy = rrand ? 1'($urandom_range(0, 1)) : rpat[cyc % rlen];
            if (dout_valid) begin
                if (k >= n) begin
                    chk("extra_word", 64'(k), 64'(n - 1));
                    exp = '0;
                end else begin
                    exp = blk[k / RL][64*(k % RL) +: 64];
                end
                chk("dout", dout, exp);
                chk("dout_last", 64'(dout_last), 64'(k == n - 1));
                if (stalled) chk("stall_hold", dout, prev);
                prev = dout; stalled = !rdy;
                if (rdy && k < n + 1) k++;
            end else begin
                chk("dout_zero", dout, 64'd0);
                stalled = 0;
            end
            dout_ready = rdy;
            perm_done = 1'b0;
            if (perm_req) begin
                chk("perm_state", 64'(perm_state == blk[p]), 64'd1);
                if (w >= pdly && p < 7) begin
                    perm_done = 1'b1; perm_result = blk[p + 1];
                    p++; w = 0;
                end else begin
                    w++;
                end
            end
            if (done) begin
                chk("done_busy", 64'(busy), 64'd1);
                fin = 1;
            end
            cyc++;
            @(negedge clk);
        end
        perm_done = 1'b0; dout_ready = 1'b0;
        if (!fin) chk("done_timeout", 64'(cyc), 64'd0);
        chk("after_done_pulse", 64'(done), 64'd0);
        chk("after_done_busy", 64'(busy), 64'd0);
        xfers = k; perms = p;
    endtask

    typedef struct {
        int          n;
        logic [15:0] rpat;
        int          rlen;
        int          pdly;
        int          exp_xfers;
        int          exp_perms;
    } vec_t;

    initial begin
        vec_t vecs [0:8];
        int xf, pm, k, cyc;

        vecs[0] = '{4,  16'h0001, 1, 0, 4,  0};  // straight run of 4
        vecs[1] = '{4,  16'h0069, 7, 0, 4,  0};  // ready 1,0,0,1,0,1,1
        vecs[2] = '{20, 16'h0001, 1, 5, 20, 1};  // cross one block, late perm_done
        vecs[3] = '{17, 16'h0001, 1, 0, 17, 0};  // exactly one block: no perm
        vecs[4] = '{18, 16'h0001, 1, 0, 18, 1};  // one past block, immediate perm_done
        vecs[5] = '{35, 16'h0002, 2, 2, 35, 2};  // two perms, half-rate consumer
        vecs[6] = '{1,  16'h0001, 1, 0, 1,  0};  // single word
        vecs[7] = '{34, 16'h0001, 1, 3, 34, 1};  // two full blocks
        vecs[8] = '{0,  16'h0001, 1, 0, 0,  0};  // zero-length request

        rst = 1'b1; start = 1'b0; state_in = '0; out_lanes = '0;
        dout_ready = 1'b0; perm_done = 1'b0; perm_result = '0;
        #1;
        chk_idle_outputs("por");
        chk("por_pstate", 64'(perm_state == '0), 64'd1);
        @(negedge clk); rst = 1'b0;

        // Async reset mid-cycle while emitting.
        start = 1'b1; state_in = fill_lanes(1); out_lanes = 8'd10;
        @(negedge clk); start = 1'b0;
        chk("pre_rst_valid", 64'(dout_valid), 64'd1);
        #3 rst = 1'b1;
        #1 chk_idle_outputs("mid_rst");
        chk("mid_rst_pstate", 64'(perm_state == '0), 64'd0 + 64'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle_outputs("idle");
        end

        // Directed table; blocks are lane i = i+1, 100+i, 200+i.
        blk[0] = fill_lanes(1); blk[1] = fill_lanes(100); blk[2] = fill_lanes(200);
        for (int b = 3; b < 8; b++) blk[b] = fill_lanes(100 * b);
        for (int v = 0; v < 9; v++) begin
            run(vecs[v].n, vecs[v].rpat, vecs[v].rlen, 1'b0, vecs[v].pdly, xf, pm);
            chk($sformatf("vec%0d_xfers", v), 64'(xf), 64'(vecs[v].exp_xfers));
            chk($sformatf("vec%0d_perms", v), 64'(pm), 64'(vecs[v].exp_perms));
        end

        // Zero-length request: done in the first cycle after start, never valid.
        @(negedge clk);
        start = 1'b1; out_lanes = 8'd0;
        @(negedge clk); start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_valid", 64'(dout_valid), 64'd0);
        @(negedge clk);
        chk("zero_done_end", 64'(done), 64'd0);
        chk("zero_busy_end", 64'(busy), 64'd0);

        // A start while busy must not disturb the squeeze in flight.
        start = 1'b1; state_in = fill_lanes(1); out_lanes = 8'd3; dout_ready = 1'b0;
        @(negedge clk);
        state_in = fill_lanes(500); out_lanes = 8'd0;
        @(negedge clk); start = 1'b0;
        chk("ign_start_busy", 64'(busy), 64'd1);
        chk("ign_start_dout", dout, 64'd1);
        dout_ready = 1'b1;
        k = 0; cyc = 0;
        while (!done && cyc < 20) begin
            if (dout_valid) begin
                chk("ign_start_word", dout, 64'(k + 1));
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        dout_ready = 1'b0;
        chk("ign_start_count", 64'(k), 64'd3);
        @(negedge clk);

        // Reset while waiting on the permutation core.
        start = 1'b1; state_in = fill_lanes(1); out_lanes = 8'd20; dout_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!perm_req && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk("perm_reached", 64'(perm_req), 64'd1);
        dout_ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk_idle_outputs("perm_rst");
        @(negedge clk); rst = 1'b0;
        perm_done = 1'b1; perm_result = fill_lanes(900);
        @(negedge clk); perm_done = 1'b0;
        chk_idle_outputs("late_pdone");
        blk[0] = rand_state();
        run(2, 16'h0001, 1, 1'b0, 0, xf, pm);
        chk("post_rst_xfers", 64'(xf), 64'd2);

        // Randomized squeezes against the block model.
        for (int t = 0; t < 10; t++) begin
            int n, d;
            n = $urandom_range(0, 60);
            d = $urandom_range(0, 6);
            for (int b = 0; b < 8; b++) blk[b] = rand_state();
            run(n, 16'h0001, 1, 1'b1, d, xf, pm);
            chk("rand_xfers", 64'(xf), 64'(n));
            chk("rand_perms", 64'(pm), 64'((n == 0) ? 0 : (n - 1) / RL));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
